ccff_bitstream_loader: RTL and testbench

//  Serialises configuration words onto the fabric configuration chain (DFFRX1 cells, ccff_head->ccff_tail).

---
 rtl/ccff_pkg.sv | 16 +
 rtl/ccff_tail_monitor.sv | 22 ++
 rtl/ccff_bitstream_loader.sv | 112 +++++++++++
 tb/tb_ccff_bitstream_loader.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/ccff_pkg.sv
// Shared types and sizing helpers for the configuration-chain loader.
package ccff_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } state_t;

  // Width needed to count from 0 up to and including n.
  function automatic int cnt_width(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/ccff_tail_monitor.sv
// Sticky error flag: remembers any 1 leaving the chain tail while the chain shifts.
module ccff_tail_monitor (
  input  logic CK,
  input  logic RN,
  input  logic clear,
  input  logic shift_en,
  input  logic tail,
  output logic error
);

  // Set on a qualified tail 1, cleared when a new load is started.
  always_ff @(posedge CK or negedge RN) begin
    if (!RN) begin
      error <= 1'b0;
    end else if (clear) begin
      error <= 1'b0;
    end else if (shift_en && tail) begin
      error <= 1'b1;
    end
  end

endmodule

// File: rtl/ccff_bitstream_loader.sv
// Serialises bitstream words MSB-first onto the configuration chain and checks
// that the bits pushed out of the tail are all zero.
module ccff_bitstream_loader
  import ccff_pkg::*;
#(
  parameter int WORD_W    = 8,
  parameter int CHAIN_LEN = 20,
  parameter int CNT_W     = cnt_width(CHAIN_LEN)
) (
  input  logic              CK,
  input  logic              RN,
  input  logic              start,
  input  logic [WORD_W-1:0] din,
  input  logic              din_valid,
  output logic              din_ready,
  output logic              ccff_head,
  output logic              ccff_shift_en,
  input  logic              ccff_tail,
  output logic              busy,
  output logic              done,
  output logic              error
);

  localparam int WCNT_W = cnt_width(WORD_W);

  state_t              state;
  state_t              state_nxt;
  logic [WORD_W-1:0]   shift_reg;
  logic [CNT_W-1:0]    bit_cnt;
  logic [WCNT_W-1:0]   word_cnt;
  logic                start_acc;
  logic                accept;
  logic                last_bit;
  logic                word_end;

  // start only counts when the loader is idle or finished; din only in LOAD.
  assign start_acc = start && (state == IDLE || state == DONE);
  assign accept    = (state == LOAD) && din_valid;
  // Compare against the pre-increment value so the transition lands on the edge
  // that shifts the final bit.
  assign last_bit  = (bit_cnt  == CNT_W'(CHAIN_LEN - 1));
  assign word_end  = (word_cnt == WCNT_W'(WORD_W - 1));

  // State register.
  always_ff @(posedge CK or negedge RN) begin
    if (!RN) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state and output decode, all outputs from registered state/data.
  always_comb begin
    state_nxt     = state;
    din_ready     = 1'b0;
    busy          = 1'b0;
    ccff_shift_en = 1'b0;
    ccff_head     = 1'b0;
    done          = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_nxt = LOAD;
      end
      LOAD: begin
        din_ready = 1'b1;
        busy      = 1'b1;
        if (din_valid) state_nxt = SHIFT;
      end
      SHIFT: begin
        busy          = 1'b1;
        ccff_shift_en = 1'b1;
        ccff_head     = shift_reg[WORD_W-1];
        if (last_bit)      state_nxt = DONE;
        else if (word_end) state_nxt = LOAD;
      end
      DONE: begin
        done = 1'b1;
        if (start) state_nxt = LOAD;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Word capture, serial shift and bit/word counters.
  always_ff @(posedge CK or negedge RN) begin
    if (!RN) begin
      shift_reg <= '0;
      bit_cnt   <= '0;
      word_cnt  <= '0;
    end else if (start_acc) begin
      bit_cnt <= '0;
    end else if (accept) begin
      shift_reg <= din;
      word_cnt  <= '0;
    end else if (state == SHIFT) begin
      shift_reg <= {shift_reg[WORD_W-2:0], 1'b0};
      bit_cnt   <= bit_cnt + CNT_W'(1);
      word_cnt  <= word_cnt + WCNT_W'(1);
    end
  end

  ccff_tail_monitor u_tail_monitor (
    .CK       (CK),
    .RN       (RN),
    .clear    (start_acc),
    .shift_en (ccff_shift_en),
    .tail     (ccff_tail),
    .error    (error)
  );

endmodule

// File: tb/tb_ccff_bitstream_loader.sv
// Directed bench for ccff_bitstream_loader (WORD_W=8, CHAIN_LEN=20).
module tb_ccff_bitstream_loader;

  logic       CK;
  logic       RN;
  logic       start;
  logic [7:0] din;
  logic       din_valid;
  logic       din_ready;
  logic       ccff_head;
  logic       ccff_shift_en;
  logic       ccff_tail;
  logic       busy;
  logic       done;
  logic       error;

  int n_cmp  = 0;
  int n_fail = 0;

  ccff_bitstream_loader #(.WORD_W(8), .CHAIN_LEN(20)) dut (
    .CK            (CK),
    .RN            (RN),
    .start         (start),
    .din           (din),
    .din_valid     (din_valid),
    .din_ready     (din_ready),
    .ccff_head     (ccff_head),
    .ccff_shift_en (ccff_shift_en),
    .ccff_tail     (ccff_tail),
    .busy          (busy),
    .done          (done),
    .error         (error)
  );

  initial CK = 1'b0;
  always #5 CK = ~CK;

  typedef struct {
    logic [7:0]  w0, w1, w2;
    int          gap;
    int          tail_at;
    bit          junk;
    bit          start_in_shift;
    logic [19:0] exp_head;
    bit          exp_err;
    int          exp_cyc;
  } vec_t;

  vec_t vecs[4];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    start     = 1'b0;
    din       = 8'h00;
    din_valid = 1'b0;
    ccff_tail = 1'b0;
  endtask

  // Entered #1 after a rising edge; runs one complete load and checks it.
  task automatic run_vec(input int id, input vec_t v);
    logic [7:0]  words[3];
    logic [19:0] hb;
    int idx, gapcnt, cyc, sh, acc, stray_head;
    logic rdy, se, hd;
    words = '{v.w0, v.w1, v.w2};
    hb = '0; idx = 0; gapcnt = 0; cyc = 0; sh = 0; acc = 0; stray_head = 0;

    start = 1'b1;
    @(posedge CK); #1;
    start = 1'b0;
    chk($sformatf("v%0d_start_ready", id), din_ready, 1);
    chk($sformatf("v%0d_start_busy", id), busy, 1);
    chk($sformatf("v%0d_start_err_clr", id), error, 0);
    chk($sformatf("v%0d_start_done_clr", id), done, 0);

    while (!done && cyc < 200) begin
      din_valid = (idx < 3 && gapcnt == 0) || (v.junk && idx >= 3);
      din       = (idx < 3) ? words[idx] : 8'hFF;
      ccff_tail = ccff_shift_en && (sh == v.tail_at);
      start     = v.start_in_shift && ccff_shift_en && (sh == 5);
      rdy = din_ready; se = ccff_shift_en; hd = ccff_head;
      if (!se && hd) stray_head++;
      @(posedge CK);
      if (se) begin hb = {hb[18:0], hd}; sh++; end
      if (rdy && din_valid) begin idx++; acc++; gapcnt = v.gap; end
      else if (rdy && gapcnt > 0) gapcnt--;
      #1;
      cyc++;
    end
    if (!done) begin
      n_cmp++; n_fail++;
      $display("FAIL v%0d_timeout: done never rose within %0d cycles", id, cyc);
    end

    chk($sformatf("v%0d_head_bits", id), hb, v.exp_head);
    chk($sformatf("v%0d_shift_cycles", id), sh, 20);
    chk($sformatf("v%0d_cycles_to_done", id), cyc, v.exp_cyc);
    chk($sformatf("v%0d_stray_head", id), stray_head, 0);

    // Hold in DONE: done/error held, extra valid words never accepted.
    ccff_tail = 1'b0;
    start     = 1'b0;
    din_valid = v.junk;
    din       = 8'hFF;
    for (int k = 0; k < 3; k++) begin
      rdy = din_ready;
      @(posedge CK);
      if (rdy && din_valid) acc++;
      #1;
    end
    chk($sformatf("v%0d_words_accepted", id), acc, 3);
    chk($sformatf("v%0d_done_held", id), done, 1);
    chk($sformatf("v%0d_busy_off", id), busy, 0);
    chk($sformatf("v%0d_error", id), error, v.exp_err);
    idle_inputs();
  endtask

  initial begin
    int sh;
    int guard;
    logic se;

    // A5,3C,F0 -> 10100101 00111100 1111 ; last word's low nibble discarded.
    vecs[0] = '{8'hA5, 8'h3C, 8'hF0, 0, -1, 1'b0, 1'b0, 20'hA53CF, 1'b0, 23};
    vecs[1] = '{8'hA5, 8'h3C, 8'hF0, 5, -1, 1'b0, 1'b0, 20'hA53CF, 1'b0, 33};
    vecs[2] = '{8'hA5, 8'h3C, 8'hF0, 0,  7, 1'b0, 1'b0, 20'hA53CF, 1'b1, 23};
    // 00,FF,5A -> 00000000 11111111 0101 ; stray start in SHIFT and valid in DONE.
    vecs[3] = '{8'h00, 8'hFF, 8'h5A, 0, -1, 1'b1, 1'b1, 20'h00FF5, 1'b0, 23};

    idle_inputs();
    RN = 1'b0;
    #12;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_error", error, 0);
    chk("rst_ready", din_ready, 0);
    chk("rst_shift_en", ccff_shift_en, 0);
    chk("rst_head", ccff_head, 0);
    RN = 1'b1;
    repeat (3) @(posedge CK);
    #1;
    chk("idle_busy", busy, 0);
    chk("idle_ready", din_ready, 0);
    chk("idle_done", done, 0);

    for (int i = 0; i < 4; i++) run_vec(i, vecs[i]);

    // Reset in the middle of SHIFT, with the tail driving 1 so error is set.
    start = 1'b1;
    @(posedge CK); #1;
    start = 1'b0;
    din_valid = 1'b1;
    din = 8'hFF;
    ccff_tail = 1'b1;
    sh = 0;
    guard = 0;
    while (sh < 9 && guard < 50) begin
      se = ccff_shift_en;
      @(posedge CK);
      if (se) sh++;
      #1;
      guard++;
    end
    chk("abort_in_shift", ccff_shift_en, 1);
    chk("abort_err_before", error, 1);
    #1 RN = 1'b0;
    #1;
    chk("abort_busy", busy, 0);
    chk("abort_shift_en", ccff_shift_en, 0);
    chk("abort_ready", din_ready, 0);
    chk("abort_head", ccff_head, 0);
    chk("abort_error", error, 0);
    idle_inputs();
    #1 RN = 1'b1;
    @(posedge CK); #1;
    chk("abort_stays_idle", busy, 0);
    run_vec(4, vecs[0]);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
